// File: rtl/hybrid_boot_pkg.sv
// Shared state encoding, output-control bundle and default sizing for the hybrid boot sequencer.
package hybrid_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CFG_RST = 3'd1,
        ST_CFG_RUN = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RUN     = 3'd4,
        ST_HALT    = 3'd5
    } boot_state_e;

    localparam int unsigned DEF_NUM_CFG        = 1;
    localparam int unsigned DEF_CNT_W          = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEF_SETTLE_CYCLES  = 1;

    // Single-bit controls that depend only on the state; cfg_reset_o mirrors config_reset.
    typedef struct packed {
        logic config_clock_en;
        logic config_reset;
        logic cgra_clock_en;
        logic cgra_reset;
        logic riscv_enable;
        logic core_rst_n;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{config_clock_en: 1'b1, config_reset: 1'b1, cgra_clock_en: 1'b0,
                                    cgra_reset: 1'b1, riscv_enable: 1'b0, core_rst_n: 1'b0};

    function automatic ctrl_t state_ctrl(input boot_state_e s);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            ST_CFG_RUN: c.config_reset = 1'b0;
            ST_SETTLE: begin
                c.config_clock_en = 1'b0;
                c.config_reset    = 1'b0;
            end
            ST_RUN: begin
                c.config_clock_en = 1'b0;
                c.config_reset    = 1'b0;
                c.cgra_clock_en   = 1'b1;
                c.cgra_reset      = 1'b0;
                c.riscv_enable    = 1'b1;
                c.core_rst_n      = 1'b1;
            end
            ST_HALT: c.config_clock_en = 1'b0;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hybrid_boot_done_tracker.sv
// Sticky per-channel configurator done latches with an all-done reduction of the post-edge value.
module hybrid_boot_done_tracker #(
    parameter int unsigned NUM_CFG = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               sample_i,
    input  logic [NUM_CFG-1:0] cfg_done_i,
    output logic [NUM_CFG-1:0] done_d_o,
    output logic               all_done_o
);

    logic [NUM_CFG-1:0] done_q;
    logic [NUM_CFG-1:0] done_d;

    always_comb begin
        done_d = done_q;
        if (clear_i) begin
            done_d = '0;
        end else if (sample_i) begin
            done_d = done_q | cfg_done_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    // Exposing the next value lets dones arriving together complete configuration in one edge.
    assign done_d_o   = done_d;
    assign all_done_o = &done_d;

endmodule

// File: rtl/hybrid_boot_sequencer.sv
// Boot sequencer: resets and configures the CGRA through its configurators, then releases CGRA and core.
module hybrid_boot_sequencer
    import hybrid_boot_pkg::*;
#(
    parameter int unsigned NUM_CFG        = DEF_NUM_CFG,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               reconfig_i,
    input  logic [NUM_CFG-1:0] cfg_done_i,
    input  logic [CNT_W-1:0]   max_cycles_i,
    output logic [NUM_CFG-1:0] cfg_enable_o,
    output logic [NUM_CFG-1:0] cfg_reset_o,
    output logic               config_clock_en_o,
    output logic               config_reset_o,
    output logic               cgra_clock_en_o,
    output logic               cgra_reset_o,
    output logic               riscv_enable_o,
    output logic               core_rst_no,
    output logic [2:0]         state_o,
    output logic               error_o,
    output logic               abort_o,
    output logic [CNT_W-1:0]   run_cycles_o
);

    localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned SET_W = cnt_width(SETTLE_CYCLES);

    boot_state_e        state_q,  state_d;
    logic [TMO_W-1:0]   tmo_q,    tmo_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [CNT_W-1:0]   run_q,    run_d;
    logic               error_q,  error_d;
    logic               abort_q,  abort_d;
    ctrl_t              ctrl_q,   ctrl_d;
    logic [NUM_CFG-1:0] cfg_en_q, cfg_en_d;
    logic [NUM_CFG-1:0] cfg_rst_q, cfg_rst_d;

    logic               clear_done;
    logic [NUM_CFG-1:0] done_next;
    logic               all_done;

    hybrid_boot_done_tracker #(
        .NUM_CFG (NUM_CFG)
    ) u_done_tracker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_done),
        .sample_i   (state_q == ST_CFG_RUN),
        .cfg_done_i (cfg_done_i),
        .done_d_o   (done_next),
        .all_done_o (all_done)
    );

    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no branch of the case can infer a latch.
        state_d    = state_q;
        tmo_d      = tmo_q;
        settle_d   = settle_q;
        run_d      = run_q;
        error_d    = error_q;
        abort_d    = abort_q;
        clear_done = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    state_d    = ST_CFG_RST;
                    error_d    = 1'b0;
                    abort_d    = 1'b0;
                    run_d      = '0;
                    clear_done = 1'b1;
                end
            end
            ST_CFG_RST: begin
                state_d = ST_CFG_RUN;
                tmo_d   = '0;
            end
            ST_CFG_RUN: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (all_done) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_HALT;
                    error_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q + SET_W'(1);
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Cycle-limit abort wins over a reconfiguration request in the same cycle.
                if ((max_cycles_i != '0) && (run_q >= max_cycles_i)) begin
                    state_d = ST_HALT;
                    abort_d = 1'b1;
                end else if (reconfig_i) begin
                    state_d    = ST_CFG_RST;
                    clear_done = 1'b1;
                end else if (run_q != '1) begin
                    run_d = run_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ctrl_d    = state_ctrl(state_d);
        cfg_en_d  = (state_d == ST_CFG_RUN) ? ~done_next : '0;
        cfg_rst_d = {NUM_CFG{ctrl_d.config_reset}};
    end

    // NOTE: non-blocking assignments so every register samples its peers' pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            settle_q  <= '0;
            run_q     <= '0;
            error_q   <= 1'b0;
            abort_q   <= 1'b0;
            ctrl_q    <= CTRL_IDLE;
            cfg_en_q  <= '0;
            cfg_rst_q <= '1;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            settle_q  <= settle_d;
            run_q     <= run_d;
            error_q   <= error_d;
            abort_q   <= abort_d;
            ctrl_q    <= ctrl_d;
            cfg_en_q  <= cfg_en_d;
            cfg_rst_q <= cfg_rst_d;
        end
    end

    assign cfg_enable_o      = cfg_en_q;
    assign cfg_reset_o       = cfg_rst_q;
    assign config_clock_en_o = ctrl_q.config_clock_en;
    assign config_reset_o    = ctrl_q.config_reset;
    assign cgra_clock_en_o   = ctrl_q.cgra_clock_en;
    assign cgra_reset_o      = ctrl_q.cgra_reset;
    assign riscv_enable_o    = ctrl_q.riscv_enable;
    assign core_rst_no       = ctrl_q.core_rst_n;
    assign state_o           = state_q;
    assign error_o           = error_q;
    assign abort_o           = abort_q;
    assign run_cycles_o      = run_q;

endmodule

// File: tb/tb_hybrid_boot_sequencer.sv
// Bench for hybrid_boot_sequencer: a phase-level reference model predicts each cycle's outputs into a
// queue that a monitor drains; directed sequences add cycle-exact checks of the boot timeline.
module tb_hybrid_boot_sequencer;
    import hybrid_boot_pkg::*;

    localparam int unsigned NCFG    = 2;
    localparam int unsigned CW      = 8;
    localparam int unsigned TMO     = 16;
    localparam int unsigned SETTLE  = 2;
    localparam int          RUN_MAX = (1 << CW) - 1;

    logic            clk_i        = 1'b0;
    logic            rst_ni       = 1'b1;
    logic            start_i      = 1'b0;
    logic            reconfig_i   = 1'b0;
    logic [NCFG-1:0] cfg_done_i   = '0;
    logic [CW-1:0]   max_cycles_i = '0;
    logic [NCFG-1:0] cfg_enable_o;
    logic [NCFG-1:0] cfg_reset_o;
    logic            config_clock_en_o;
    logic            config_reset_o;
    logic            cgra_clock_en_o;
    logic            cgra_reset_o;
    logic            riscv_enable_o;
    logic            core_rst_no;
    logic [2:0]      state_o;
    logic            error_o;
    logic            abort_o;
    logic [CW-1:0]   run_cycles_o;

    hybrid_boot_sequencer #(
        .NUM_CFG        (NCFG),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TMO),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .start_i           (start_i),
        .reconfig_i        (reconfig_i),
        .cfg_done_i        (cfg_done_i),
        .max_cycles_i      (max_cycles_i),
        .cfg_enable_o      (cfg_enable_o),
        .cfg_reset_o       (cfg_reset_o),
        .config_clock_en_o (config_clock_en_o),
        .config_reset_o    (config_reset_o),
        .cgra_clock_en_o   (cgra_clock_en_o),
        .cgra_reset_o      (cgra_reset_o),
        .riscv_enable_o    (riscv_enable_o),
        .core_rst_no       (core_rst_no),
        .state_o           (state_o),
        .error_o           (error_o),
        .abort_o           (abort_o),
        .run_cycles_o      (run_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]      state;
        logic [NCFG-1:0] cfg_en;
        logic [NCFG-1:0] cfg_rst;
        logic            cfg_clk_en;
        logic            cfg_reset;
        logic            cgra_clk_en;
        logic            cgra_reset;
        logic            riscv_en;
        logic            core_rst_n;
        logic            err;
        logic            abort;
        logic [CW-1:0]   run;
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    obs_t exp_q[$];

    // Reference model: phase, cycles spent in the phase, sticky dones, flags and RUN count.
    boot_state_e     m_ph;
    logic [NCFG-1:0] m_done;
    int              m_elapsed;
    int              m_run;
    bit              m_err;
    bit              m_abort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d (t=%0t): got %0h, expected %0h", name, cyc, $time, act, exp);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.state       = state_o;
        o.cfg_en      = cfg_enable_o;
        o.cfg_rst     = cfg_reset_o;
        o.cfg_clk_en  = config_clock_en_o;
        o.cfg_reset   = config_reset_o;
        o.cgra_clk_en = cgra_clock_en_o;
        o.cgra_reset  = cgra_reset_o;
        o.riscv_en    = riscv_enable_o;
        o.core_rst_n  = core_rst_no;
        o.err         = error_o;
        o.abort       = abort_o;
        o.run         = run_cycles_o;
        return o;
    endfunction

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        check({tag, ".state"},       32'(a.state),       32'(e.state));
        check({tag, ".cfg_enable"},  32'(a.cfg_en),      32'(e.cfg_en));
        check({tag, ".cfg_reset"},   32'(a.cfg_rst),     32'(e.cfg_rst));
        check({tag, ".config_clk"},  32'(a.cfg_clk_en),  32'(e.cfg_clk_en));
        check({tag, ".config_rst"},  32'(a.cfg_reset),   32'(e.cfg_reset));
        check({tag, ".cgra_clk"},    32'(a.cgra_clk_en), 32'(e.cgra_clk_en));
        check({tag, ".cgra_rst"},    32'(a.cgra_reset),  32'(e.cgra_reset));
        check({tag, ".riscv_en"},    32'(a.riscv_en),    32'(e.riscv_en));
        check({tag, ".core_rst_n"},  32'(a.core_rst_n),  32'(e.core_rst_n));
        check({tag, ".error"},       32'(a.err),         32'(e.err));
        check({tag, ".abort"},       32'(a.abort),       32'(e.abort));
        check({tag, ".run_cycles"},  32'(a.run),         32'(e.run));
    endtask

    task automatic model_reset();
        m_ph      = ST_IDLE;
        m_done    = '0;
        m_elapsed = 0;
        m_run     = 0;
        m_err     = 1'b0;
        m_abort   = 1'b0;
    endtask

    // Outputs by phase: IDLE/CFG_RST hold everything in reset with config clock on; CFG_RUN releases
    // configurators; SETTLE stops the config clock; RUN releases CGRA and core; HALT stops all clocks.
    function automatic obs_t model_obs();
        obs_t o;
        o.state       = m_ph;
        o.cfg_en      = '0;
        o.cfg_rst     = '1;
        o.cfg_clk_en  = 1'b1;
        o.cfg_reset   = 1'b1;
        o.cgra_clk_en = 1'b0;
        o.cgra_reset  = 1'b1;
        o.riscv_en    = 1'b0;
        o.core_rst_n  = 1'b0;
        o.err         = m_err;
        o.abort       = m_abort;
        o.run         = CW'(m_run);
        if (m_ph == ST_CFG_RUN) begin
            o.cfg_en    = ~m_done;
            o.cfg_rst   = '0;
            o.cfg_reset = 1'b0;
        end else if (m_ph == ST_SETTLE) begin
            o.cfg_clk_en = 1'b0;
            o.cfg_rst    = '0;
            o.cfg_reset  = 1'b0;
        end else if (m_ph == ST_RUN) begin
            o.cfg_clk_en  = 1'b0;
            o.cfg_rst     = '0;
            o.cfg_reset   = 1'b0;
            o.cgra_clk_en = 1'b1;
            o.cgra_reset  = 1'b0;
            o.riscv_en    = 1'b1;
            o.core_rst_n  = 1'b1;
        end else if (m_ph == ST_HALT) begin
            o.cfg_clk_en = 1'b0;
        end
        return o;
    endfunction

    task automatic model_edge(input bit st, input bit rc, input logic [NCFG-1:0] dn, input int maxc);
        case (m_ph)
            ST_IDLE, ST_HALT: begin
                if (st) begin
                    m_ph    = ST_CFG_RST;
                    m_err   = 1'b0;
                    m_abort = 1'b0;
                    m_run   = 0;
                    m_done  = '0;
                end
            end
            ST_CFG_RST: begin
                m_ph      = ST_CFG_RUN;
                m_elapsed = 0;
            end
            ST_CFG_RUN: begin
                m_done    = m_done | dn;
                m_elapsed = m_elapsed + 1;
                if (&m_done) begin
                    m_ph      = ST_SETTLE;
                    m_elapsed = 0;
                end else if (m_elapsed == int'(TMO)) begin
                    m_ph  = ST_HALT;
                    m_err = 1'b1;
                end
            end
            ST_SETTLE: begin
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == int'(SETTLE)) m_ph = ST_RUN;
            end
            ST_RUN: begin
                if (maxc != 0 && m_run >= maxc) begin
                    m_ph    = ST_HALT;
                    m_abort = 1'b1;
                end else if (rc) begin
                    m_ph   = ST_CFG_RST;
                    m_done = '0;
                end else if (m_run < RUN_MAX) begin
                    m_run = m_run + 1;
                end
            end
            default: m_ph = ST_IDLE;
        endcase
    endtask

    // Called at a falling edge: drive one cycle of inputs, predict, then advance to the next falling edge.
    task automatic step(input bit st, input bit rc, input logic [NCFG-1:0] dn);
        start_i    = st;
        reconfig_i = rc;
        cfg_done_i = dn;
        model_edge(st, rc, dn, int'(max_cycles_i));
        exp_q.push_back(model_obs());
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    always @(posedge clk_i) begin : monitor
        obs_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp_obs("mon", dut_obs(), e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1 rst_ni = 1'b0;
        #2 cmp_obs("reset", dut_obs(), model_obs());
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cmp_obs("idle", dut_obs(), model_obs());

        // Boot timeline: start at 0, done[0] at 5, done[1] at 9.
        cyc = 0;
        step(1'b1, 1'b0, 2'b00);
        check("cfg_rst_state", 32'(state_o), 32'(ST_CFG_RST));
        repeat (4) step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b01);
        check("en0_dropped_c6", 32'(cfg_enable_o[0]), 32'd0);
        check("en1_held_c6", 32'(cfg_enable_o[1]), 32'd1);
        repeat (3) step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b10);
        check("settle_c10", 32'(state_o), 32'(ST_SETTLE));
        step(1'b0, 1'b0, 2'b11);
        check("settle_c11", 32'(state_o), 32'(ST_SETTLE));
        check("cgra_rst_c11", 32'(cgra_reset_o), 32'd1);
        step(1'b0, 1'b0, 2'b00);
        check("riscv_en_c12", 32'(riscv_enable_o), 32'd1);
        check("cgra_rst_c12", 32'(cgra_reset_o), 32'd0);

        // Reconfiguration from RUN, then back to RUN.
        step(1'b0, 1'b1, 2'b00);
        check("reconf_state", 32'(state_o), 32'(ST_CFG_RST));
        check("reconf_riscv", 32'(riscv_enable_o), 32'd0);
        check("reconf_core_rst", 32'(core_rst_no), 32'd0);
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b11);
        repeat (2) step(1'b0, 1'b0, 2'b00);
        check("reconf_back_run", 32'(state_o), 32'(ST_RUN));
        check("reconf_back_riscv", 32'(riscv_enable_o), 32'd1);

        // Unlimited RUN saturates the counter; then abort beats a simultaneous reconfig.
        repeat (260) step(1'b0, 1'b0, 2'b00);
        check("run_saturated", 32'(run_cycles_o), 32'(RUN_MAX));
        check("run_still_running", 32'(state_o), 32'(ST_RUN));
        max_cycles_i = 8'd1;
        step(1'b0, 1'b1, 2'b00);
        check("abort_prio_state", 32'(state_o), 32'(ST_HALT));
        check("abort_prio_flag", 32'(abort_o), 32'd1);

        // Timeout with no dones: HALT after 16 CFG_RUN cycles.
        max_cycles_i = '0;
        cyc = 0;
        step(1'b1, 1'b0, 2'b00);
        check("restart_abort_clr", 32'(abort_o), 32'd0);
        repeat (16) step(1'b0, 1'b0, 2'b00);
        check("tmo_c17_cfg_run", 32'(state_o), 32'(ST_CFG_RUN));
        step(1'b0, 1'b0, 2'b00);
        check("tmo_halt", 32'(state_o), 32'(ST_HALT));
        check("tmo_error", 32'(error_o), 32'd1);
        check("tmo_cgra_rst", 32'(cgra_reset_o), 32'd1);
        check("tmo_riscv", 32'(riscv_enable_o), 32'd0);

        // Last done lands on the timeout cycle: SETTLE wins, no error.
        cyc = 0;
        step(1'b1, 1'b0, 2'b00);
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b0, (i == 3) ? 2'b01 : 2'b00);
        step(1'b0, 1'b0, 2'b10);
        check("tmo_tie_settle", 32'(state_o), 32'(ST_SETTLE));
        check("tmo_tie_no_err", 32'(error_o), 32'd0);
        repeat (2) step(1'b0, 1'b0, 2'b00);

        // Cycle limit 100: RUN starts at cycle 20, count reaches 100 at cycle 120.
        max_cycles_i = 8'd100;
        while (cyc < 120) step(1'b0, 1'b0, 2'b00);
        check("limit_run_100", 32'(run_cycles_o), 32'd100);
        check("limit_still_run", 32'(state_o), 32'(ST_RUN));
        step(1'b0, 1'b0, 2'b00);
        check("limit_halt", 32'(state_o), 32'(ST_HALT));
        check("limit_abort", 32'(abort_o), 32'd1);
        check("limit_cgra_clk", 32'(cgra_clock_en_o), 32'd0);
        check("limit_riscv", 32'(riscv_enable_o), 32'd0);

        // Asynchronous reset between edges in the middle of CFG_RUN.
        max_cycles_i = '0;
        cyc = 0;
        step(1'b1, 1'b0, 2'b00);
        repeat (2) step(1'b0, 1'b0, 2'b00);
        check("pre_areset_cfg_run", 32'(state_o), 32'(ST_CFG_RUN));
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        cmp_obs("areset", dut_obs(), model_obs());
        @(negedge clk_i);
        rst_ni = 1'b1;
        cmp_obs("areset_held", dut_obs(), model_obs());

        // Random traffic, including start/reconfig/done in phases where they must be ignored.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                max_cycles_i = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(1, 40));
            end
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0});
        end

        @(negedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hybrid_boot_sequencer.md
HYBRID_BOOT_SEQUENCER -- requirements
Module: hybrid_boot_sequencer

Interface
REQ-001 Parameter NUM_CFG, default 1: number of CGRA configurator channels.
REQ-002 Parameter CNT_W, default 32: width of the run-cycle counter and the limit input.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: CFG_RUN cycles allowed before timeout.
REQ-004 Parameter SETTLE_CYCLES, default 1 (legal range 1 or more): cycles spent in SETTLE.
REQ-005 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 start_i  in  1  begin the boot sequence; sampled only in IDLE or HALT.
REQ-008 reconfig_i  in  1  re-run configuration; sampled only in RUN.
REQ-009 cfg_done_i  in  NUM_CFG  per-channel configurator done.
REQ-010 max_cycles_i  in  CNT_W  RUN cycle limit; 0 means unlimited.
REQ-011 cfg_enable_o  out  NUM_CFG  per-channel configurator enable.
REQ-012 cfg_reset_o  out  NUM_CFG  per-channel configurator reset, active-high.
REQ-013 config_clock_en_o / config_reset_o  out  1 each  CGRA config-chain clock enable and reset.
REQ-014 cgra_clock_en_o / cgra_reset_o  out  1 each  CGRA datapath clock enable and reset, reset active-high.
REQ-015 riscv_enable_o  out  1  core enable.
REQ-016 core_rst_no  out  1  core reset, active-low.
REQ-017 state_o  out  3  current state encoding.
REQ-018 error_o / abort_o  out  1 each  sticky timeout flag / sticky cycle-limit flag.
REQ-019 run_cycles_o  out  CNT_W  RUN cycle count.

Function
REQ-020 The FSM SHALL have six states: IDLE, CFG_RST, CFG_RUN, SETTLE, RUN, HALT. Every output is driven from a register.
REQ-021 IDLE or HALT with start_i=1 -> CFG_RST at the next edge; this clears error_o, abort_o, the done latches and run_cycles_o.
REQ-022 CFG_RST SHALL last exactly 1 cycle.
 - config_reset_o=1, cfg_reset_o all 1, config_clock_en_o=1, cgra_reset_o=1, riscv_enable_o=0, core_rst_no=0.
 - Then -> CFG_RUN.
REQ-023 CFG_RUN outputs: config_reset_o=0, cfg_reset_o=0, config_clock_en_o=1; cfg_enable_o[i]=1 until done[i] is latched.
REQ-024 Each channel's done latch is sticky; cfg_enable_o[i] SHALL drop on the cycle after cfg_done_i[i] is sampled.
REQ-025 All done latches set -> SETTLE at the next edge.
 - Dones arriving in the same cycle count together.
 - cfg_done_i SHALL be ignored outside CFG_RUN.
REQ-026 The timeout counter SHALL clear on entry to CFG_RUN and increment each CFG_RUN cycle.
 - Reaching TIMEOUT_CYCLES without all dones -> HALT with error_o=1.
 - All dones in the same cycle as the timeout -> SETTLE, no error.
REQ-027 SETTLE: config_clock_en_o=0, cfg_enable_o=0, cgra_reset_o still 1; stay SETTLE_CYCLES cycles, then -> RUN.
REQ-028 RUN: cgra_reset_o=0, cgra_clock_en_o=1, core_rst_no=1, riscv_enable_o=1.
 - run_cycles_o increments each cycle and saturates at all-ones.
REQ-029 In RUN, if max_cycles_i!=0 and run_cycles_o>=max_cycles_i -> HALT with abort_o=1.
 - abort has priority over a simultaneous reconfig_i.
REQ-030 reconfig_i in RUN -> CFG_RST, so the core and CGRA are back in reset on the next cycle.
REQ-031 HALT: all enables 0, all clock enables 0, all resets asserted, flags held.
REQ-032 start_i outside IDLE/HALT and reconfig_i outside RUN SHALL be ignored.

Reset
REQ-033 rst_ni low SHALL immediately force the following, regardless of state:
 - state IDLE;
 - config_clock_en_o=1, config_reset_o=1, cfg_reset_o all 1, cfg_enable_o=0;
 - cgra_reset_o=1, cgra_clock_en_o=0;
 - riscv_enable_o=0, core_rst_no=0;
 - error_o=0, abort_o=0, run_cycles_o=0, all counters and latches 0.
REQ-034 IDLE outputs SHALL equal the reset values.

Structure
REQ-035 Package hybrid_boot_pkg SHALL hold the state enum (3-bit) and the default parameter constants.
REQ-036 A sub-module hybrid_boot_done_tracker SHALL contain the NUM_CFG sticky done latches and the all-done reduction; all other logic is in the top.

Verification
REQ-037 NUM_CFG=2, SETTLE_CYCLES=2; start_i at cycle 0, done[0] at cycle 5, done[1] at cycle 9 -> all of the following:
 - cfg_enable_o[0]=0 from cycle 6;
 - SETTLE in cycles 10-11;
 - riscv_enable_o=1 and cgra_reset_o=0 from cycle 12.
REQ-038 TIMEOUT_CYCLES=16, no dones -> HALT after 16 CFG_RUN cycles with error_o=1, cgra_reset_o=1, riscv_enable_o=0.
REQ-039 max_cycles_i=100 -> run_cycles_o reaches 100, then HALT with abort_o=1, cgra_clock_en_o=0, riscv_enable_o=0.
REQ-040 reconfig_i pulse in RUN -> next cycle CFG_RST, riscv_enable_o=0, core_rst_no=0; full reconfiguration then returns to RUN.
REQ-041 rst_ni low mid-CFG_RUN, between clock edges -> all outputs at reset values before the next edge.
REQ-042 Last done and timeout in the same cycle -> SETTLE, error_o=0.
